// File: rtl/player_hit_manager.sv
// Player hit manager: player hits -> lives/death delay/respawn invulnerability; enemy hits -> saturating score.
// Latency 1 cycle, all outputs registered; no backpressure (pulse inputs); PLAYER_HIT_BLINK_EN adds INVULN blinking.
module player_hit_manager #(
    parameter int LIVES_INIT    = 3,
    parameter int DEATH_FRAMES  = 30,
    parameter int INVULN_FRAMES = 60,
    parameter int ENEMY_POINTS  = 10,
    parameter int SCORE_W       = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               start_game,
    input  logic               SingleHitPulse_player,
    input  logic               SingleHitPulse_enemies,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               invulnerable,
    output logic               player_visible,
    output logic               respawn_pulse,
    output logic               game_over,
    output logic [2:0]         fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ALIVE     = 3'd1,
        S_DYING     = 3'd2,
        S_INVULN    = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    localparam int MAX_FRAMES = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
    localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [CNT_W-1:0]   DEATH_LAST  = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0]   INVULN_LAST = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [SCORE_W:0]   SCORE_MAX   = {1'b0, {SCORE_W{1'b1}}};
    localparam logic [SCORE_W:0]   POINTS      = (SCORE_W+1)'(ENEMY_POINTS);
    localparam logic [2:0]         LIVES_LOAD  = 3'(LIVES_INIT);

    state_t             state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               invulnerable_q, invulnerable_d;
    logic               player_visible_q, player_visible_d;
    logic               respawn_pulse_q, respawn_pulse_d;
    logic               game_over_q, game_over_d;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

`ifdef PLAYER_HIT_BLINK_EN
    // Free-running frame phase inside INVULN; bit 2 selects the hidden half of each 8-frame period.
    logic [2:0] blink_phase_q, blink_phase_d;
`endif

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        cnt_d     = cnt_q;
        score_sum = {1'b0, score_q} + POINTS;
        score_sat = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_game) begin
                    lives_d = LIVES_LOAD;
                    score_d = '0;
                    cnt_d   = '0;
                    state_d = S_ALIVE;
                end
            end
            S_ALIVE: begin
                if (SingleHitPulse_enemies) begin
                    score_d = score_sat;
                end
                // A frame pulse coinciding with the hit is deliberately not counted.
                if (SingleHitPulse_player) begin
                    lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                    cnt_d   = '0;
                    state_d = S_DYING;
                end
            end
            S_DYING: begin
                if (startOfFrame) begin
                    if (cnt_q == DEATH_LAST) begin
                        cnt_d   = '0;
                        state_d = (lives_q == 3'd0) ? S_GAME_OVER : S_INVULN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_INVULN: begin
                if (SingleHitPulse_enemies) begin
                    score_d = score_sat;
                end
                if (startOfFrame) begin
                    if (cnt_q == INVULN_LAST) begin
                        cnt_d   = '0;
                        state_d = S_ALIVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

`ifdef PLAYER_HIT_BLINK_EN
        blink_phase_d = blink_phase_q;
        if (state_d == S_INVULN && state_q != S_INVULN) begin
            blink_phase_d = 3'd0;
        end else if (state_q == S_INVULN && state_d == S_INVULN && startOfFrame) begin
            blink_phase_d = blink_phase_q + 3'd1;
        end
`endif

        invulnerable_d  = (state_d == S_DYING) || (state_d == S_INVULN);
        game_over_d     = (state_d == S_GAME_OVER);
        respawn_pulse_d = (state_q == S_DYING) && (state_d == S_INVULN);
        case (state_d)
            S_ALIVE:  player_visible_d = 1'b1;
`ifdef PLAYER_HIT_BLINK_EN
            S_INVULN: player_visible_d = ~blink_phase_d[2];
`else
            S_INVULN: player_visible_d = 1'b1;
`endif
            default:  player_visible_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            lives_q          <= 3'd0;
            score_q          <= '0;
            cnt_q            <= '0;
            invulnerable_q   <= 1'b0;
            player_visible_q <= 1'b0;
            respawn_pulse_q  <= 1'b0;
            game_over_q      <= 1'b0;
`ifdef PLAYER_HIT_BLINK_EN
            blink_phase_q    <= 3'd0;
`endif
        end else begin
            state_q          <= state_d;
            lives_q          <= lives_d;
            score_q          <= score_d;
            cnt_q            <= cnt_d;
            invulnerable_q   <= invulnerable_d;
            player_visible_q <= player_visible_d;
            respawn_pulse_q  <= respawn_pulse_d;
            game_over_q      <= game_over_d;
`ifdef PLAYER_HIT_BLINK_EN
            blink_phase_q    <= blink_phase_d;
`endif
        end
    end

    assign lives          = lives_q;
    assign score          = score_q;
    assign invulnerable   = invulnerable_q;
    assign player_visible = player_visible_q;
    assign respawn_pulse  = respawn_pulse_q;
    assign game_over      = game_over_q;
    assign fsm_state      = state_q;

endmodule
